// File: rtl/stepgen_if.sv
// Host register bus for stepgen_ctrl.
// Write strobe/address/data plus a registered read port.
interface stepgen_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/stepgen_ctrl.sv
// Step generator bank controller: shadow registers, atomic commit,
// IDLE/RUN/FAULT enable sequencing and commit watchdog.
module stepgen_ctrl #(
    parameter int N  = 4,
    parameter int F  = 10,
    parameter int T  = 5,
    parameter int WD = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    stepgen_if.slave             bus,
    input  logic                 wd_tick,
    output logic [N*(F+1)-1:0]   velocity,
    output logic [T-1:0]         dirtime,
    output logic [T-1:0]         steptime,
    output logic                 enable,
    output logic                 fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        r_state;
    logic [F:0]    r_shadow [N];
    logic [F:0]    r_vel    [N];
    logic [T-1:0]  r_sh_dt;
    logic [T-1:0]  r_sh_st;
    logic [T-1:0]  r_dt;
    logic [T-1:0]  r_st;
    logic [WD-1:0] r_wd_reload;
    logic [WD-1:0] r_wd_count;
    logic          r_en_req;
    logic          r_enable;
    logic          r_fault;
    logic [15:0]   r_rd_data;

    logic          w_ctrl;
    logic          w_en_new;
    logic          w_commit;
    logic          w_wd_on;
    logic          w_expire;
    logic [15:0]   w_rd;

    assign w_ctrl   = bus.wr_en && (bus.wr_addr == 4'd9);
    assign w_en_new = w_ctrl ? bus.wr_data[0] : r_en_req;
    assign w_commit = w_ctrl && bus.wr_data[1] && (r_state != S_FAULT);
    assign w_wd_on  = (r_state == S_RUN) && wd_tick && (r_wd_reload != '0);
    // A tick on count 0 or 1 expires, unless a commit reloads this cycle.
    assign w_expire = w_wd_on && (r_wd_count <= WD'(1)) && !w_commit;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) r_shadow[i] <= '0;
            r_sh_dt     <= '0;
            r_sh_st     <= '0;
            r_wd_reload <= '0;
            r_en_req    <= 1'b0;
        end else if (bus.wr_en) begin
            for (int i = 0; i < N; i++)
                if (bus.wr_addr == 4'(i))
                    r_shadow[i] <= bus.wr_data[F:0];
            if (bus.wr_addr == 4'd8) begin
                r_sh_dt <= bus.wr_data[T-1:0];
                r_sh_st <= bus.wr_data[8+T-1:8];
            end
            if (bus.wr_addr == 4'd9)
                r_en_req <= bus.wr_data[0];
            if (bus.wr_addr == 4'd10)
                r_wd_reload <= bus.wr_data[WD-1:0];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < N; i++) r_vel[i] <= '0;
            r_dt       <= '0;
            r_st       <= '0;
            r_wd_count <= '0;
            r_enable   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            if (w_commit) begin
                for (int i = 0; i < N; i++) r_vel[i] <= r_shadow[i];
                r_dt       <= r_sh_dt;
                r_st       <= r_sh_st;
                r_wd_count <= r_wd_reload;
            end else if (w_wd_on && (r_wd_count != '0)) begin
                r_wd_count <= r_wd_count - 1'b1;
            end

            // Later assignments below override the commit's velocity load.
            case (r_state)
                S_IDLE: begin
                    if (w_commit && w_en_new) begin
                        r_state  <= S_RUN;
                        r_enable <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_ctrl && !w_en_new) begin
                        r_state  <= S_IDLE;
                        r_enable <= 1'b0;
                        for (int i = 0; i < N; i++) r_vel[i] <= '0;
                    end else if (w_expire) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        for (int i = 0; i < N; i++) r_vel[i] <= '0;
                    end
                end
                S_FAULT: begin
                    if (w_ctrl && !bus.wr_data[0]) begin
                        r_state  <= S_IDLE;
                        r_enable <= 1'b0;
                        r_fault  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N; i++)
            if (bus.rd_addr == 4'(i))
                w_rd = {{(15-F){r_vel[i][F]}}, r_vel[i]};
        case (bus.rd_addr)
            4'd8: begin
                w_rd[T-1:0]   = r_dt;
                w_rd[8+T-1:8] = r_st;
            end
            4'd9:  w_rd[2:0] = {r_fault, r_state == S_RUN, r_en_req};
            4'd10: w_rd[WD-1:0] = r_wd_count;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_rd_data <= '0;
        else         r_rd_data <= w_rd;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_vel
        assign velocity[gi*(F+1) +: F+1] = r_vel[gi];
    end

    assign dirtime     = r_dt;
    assign steptime    = r_st;
    assign enable      = r_enable;
    assign fault       = r_fault;
    assign bus.rd_data = r_rd_data;

endmodule

// File: tb/tb_stepgen_ctrl.sv
// Self-checking bench for stepgen_ctrl against a register-level
// reference model of shadows, commits, watchdog and enable states.
module tb_stepgen_ctrl;
    localparam int N  = 4;
    localparam int F  = 10;
    localparam int T  = 5;
    localparam int WD = 16;
    localparam int VW = F + 1;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic wd_tick = 1'b0;
    logic [N*VW-1:0] velocity;
    logic [T-1:0] dirtime, steptime;
    logic enable, fault;

    stepgen_if bus ();

    stepgen_ctrl #(.N(N), .F(F), .T(T), .WD(WD)) dut (
        .clk(clk), .nreset(nreset), .bus(bus), .wd_tick(wd_tick),
        .velocity(velocity), .dirtime(dirtime), .steptime(steptime),
        .enable(enable), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // model: 0 idle, 1 run, 2 fault
    int m_sh [N];
    int m_act [N];
    int m_sdt, m_sst, m_dt, m_st, m_en, m_rel, m_cnt, m_state;
    logic [15:0] exp_rd;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_sh[i] = 0; m_act[i] = 0; end
        m_sdt = 0; m_sst = 0; m_dt = 0; m_st = 0;
        m_en = 0; m_rel = 0; m_cnt = 0; m_state = 0;
        exp_rd = '0;
    endtask

    function automatic logic [15:0] rd_model(input int a);
        int v;
        if (a < N) begin
            v = m_act[a];
            if (v >= (1 << F)) v -= (1 << VW);
            return 16'(v);
        end
        if (a == 8) return 16'((m_st << 8) | m_dt);
        if (a == 9) return 16'(((m_state == 2) << 2) | ((m_state == 1) << 1) | m_en);
        if (a == 10) return 16'(m_cnt);
        return 16'h0;
    endfunction

    function automatic logic [N*VW-1:0] exp_vel();
        logic [N*VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*VW +: VW] = VW'(m_act[i]);
        return v;
    endfunction

    task automatic model_step(input logic we, input logic [3:0] a,
                              input logic [15:0] d, input logic tk,
                              input logic [3:0] ra);
        int ad, old_rel, old_cnt, new_en;
        bit is_ctrl, commit, expire;
        ad = int'(a);
        exp_rd = rd_model(int'(ra));
        old_rel = m_rel;
        old_cnt = m_cnt;
        is_ctrl = we && ad == 9;
        commit = is_ctrl && d[1] && m_state != 2;
        new_en = is_ctrl ? int'(d[0]) : m_en;
        if (we && ad < N) m_sh[ad] = int'(d) % (1 << VW);
        if (we && ad == 8) begin
            m_sdt = int'(d) % (1 << T);
            m_sst = (int'(d) / 256) % (1 << T);
        end
        if (we && ad == 10) m_rel = int'(d) % (1 << WD);
        expire = 0;
        if (commit) begin
            for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
            m_dt = m_sdt; m_st = m_sst; m_cnt = old_rel;
        end else if (m_state == 1 && tk && old_rel != 0) begin
            if (m_cnt > 0) m_cnt--;
            expire = old_cnt <= 1;
        end
        m_en = new_en;
        if (m_state == 0) begin
            if (commit && new_en == 1) m_state = 1;
        end else if (m_state == 1) begin
            if (is_ctrl && new_en == 0) begin
                m_state = 0;
                for (int i = 0; i < N; i++) m_act[i] = 0;
            end else if (expire) begin
                m_state = 2;
                for (int i = 0; i < N; i++) m_act[i] = 0;
            end
        end else begin
            if (is_ctrl && new_en == 0) m_state = 0;
        end
    endtask

    task automatic cyc(input logic we, input logic [3:0] a,
                       input logic [15:0] d, input logic tk,
                       input logic [3:0] ra);
        bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
        wd_tick = tk; bus.rd_addr = ra;
        @(posedge clk);
        model_step(we, a, d, tk, ra);
        #1;
        bus.wr_en = 1'b0; wd_tick = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++; if (velocity !== '0 || enable !== 1'b0 || fault !== 1'b0)
            $display("FAIL reset_outputs vel=%h en=%b flt=%b", velocity, enable, fault);
        else n_pass++;
        cyc(1, 4'd0, 16'h0123, 0, 0);
        cyc(1, 4'd9, 16'h0003, 0, 0);
        n_chk++; if (velocity[VW-1:0] !== 11'h123 || enable !== 1'b1)
            $display("FAIL reset_prerun vel=%h en=%b exp vel0=123 en=1", velocity, enable);
        else n_pass++;
        nreset = 1'b0;
        #1;
        n_chk++; if (velocity !== '0 || enable !== 1'b0 || dirtime !== '0 ||
                     steptime !== '0 || fault !== 1'b0 || bus.rd_data !== 16'h0)
            $display("FAIL reset_async vel=%h en=%b dt=%h st=%h flt=%b rd=%h",
                     velocity, enable, dirtime, steptime, fault, bus.rd_data);
        else n_pass++;
        model_reset();
        #3 nreset = 1'b1;
        cyc(0, 4'd0, 16'h0, 0, 4'd9);
        n_chk++; if (bus.rd_data !== 16'h0 || bus.rd_data !== exp_rd)
            $display("FAIL reset_state got=%h exp=%h", bus.rd_data, exp_rd);
        else n_pass++;
    endtask

    task automatic test_atomic_commit();
        cyc(1, 4'd0, 16'h07FF, 0, 0);
        cyc(1, 4'd1, 16'h0401, 0, 0);
        cyc(1, 4'd8, 16'h0A03, 0, 0);
        n_chk++; if (velocity !== '0 || dirtime !== '0 || steptime !== '0 || enable !== 1'b0)
            $display("FAIL atomic_pre vel=%h dt=%h st=%h en=%b exp all 0",
                     velocity, dirtime, steptime, enable);
        else n_pass++;
        cyc(1, 4'd9, 16'h0003, 0, 0);
        n_chk++; if (velocity[VW-1:0] !== 11'h7FF || velocity[2*VW-1:VW] !== 11'h401 ||
                     dirtime !== 5'd3 || steptime !== 5'd10 || enable !== 1'b1 ||
                     velocity !== exp_vel())
            $display("FAIL atomic_commit vel=%h dt=%0d st=%0d en=%b exp vel=%h dt=3 st=10 en=1",
                     velocity, dirtime, steptime, enable, exp_vel());
        else n_pass++;
        cyc(0, 4'd0, 16'h0, 0, 4'd0);
        n_chk++; if (bus.rd_data !== 16'hFFFF)
            $display("FAIL atomic_rd0 got=%h exp=ffff", bus.rd_data);
        else n_pass++;
        cyc(0, 4'd0, 16'h0, 0, 4'd1);
        n_chk++; if (bus.rd_data !== 16'hFC01)
            $display("FAIL atomic_rd1 got=%h exp=fc01", bus.rd_data);
        else n_pass++;
    endtask

    task automatic test_watchdog_expiry();
        cyc(1, 4'd10, 16'h0003, 0, 0);
        cyc(1, 4'd9, 16'h0003, 0, 0);
        cyc(0, 4'd0, 16'h0, 1, 0);
        cyc(0, 4'd0, 16'h0, 1, 0);
        n_chk++; if (fault !== 1'b0 || velocity[VW-1:0] !== 11'h7FF)
            $display("FAIL wd_early flt=%b vel=%h exp flt=0", fault, velocity);
        else n_pass++;
        cyc(0, 4'd0, 16'h0, 1, 0);
        n_chk++; if (fault !== 1'b1 || velocity !== '0 || enable !== 1'b1)
            $display("FAIL wd_expire flt=%b vel=%h en=%b exp 1/0/1", fault, velocity, enable);
        else n_pass++;
        cyc(1, 4'd9, 16'h0000, 0, 0);
        n_chk++; if (fault !== 1'b0 || enable !== 1'b0)
            $display("FAIL wd_clear flt=%b en=%b exp 0/0", fault, enable);
        else n_pass++;
    endtask

    task automatic test_collision();
        cyc(1, 4'd10, 16'h0003, 0, 0);
        cyc(1, 4'd9, 16'h0003, 0, 0);
        cyc(0, 4'd0, 16'h0, 1, 0);
        cyc(0, 4'd0, 16'h0, 1, 0);
        cyc(1, 4'd9, 16'h0003, 1, 0);
        n_chk++; if (fault !== 1'b0 || enable !== 1'b1)
            $display("FAIL collide_flt flt=%b en=%b exp 0/1", fault, enable);
        else n_pass++;
        cyc(0, 4'd0, 16'h0, 0, 4'd10);
        n_chk++; if (bus.rd_data !== 16'd3 || bus.rd_data !== exp_rd)
            $display("FAIL collide_cnt got=%h exp=%h", bus.rd_data, exp_rd);
        else n_pass++;
    endtask

    task automatic test_wd_disabled();
        cyc(1, 4'd10, 16'h0000, 0, 0);
        cyc(1, 4'd9, 16'h0003, 0, 0);
        for (int i = 0; i < 1000; i++) cyc(0, 4'd0, 16'h0, 1, 4'd10);
        n_chk++; if (fault !== 1'b0 || enable !== 1'b1 || bus.rd_data !== 16'h0)
            $display("FAIL wd_off flt=%b en=%b cnt=%h exp 0/1/0", fault, enable, bus.rd_data);
        else n_pass++;
    endtask

    task automatic test_fault_ignores_commit();
        cyc(1, 4'd10, 16'h0002, 0, 0);
        cyc(1, 4'd9, 16'h0003, 0, 0);
        cyc(0, 4'd0, 16'h0, 1, 0);
        cyc(0, 4'd0, 16'h0, 1, 0);
        n_chk++; if (fault !== 1'b1)
            $display("FAIL fc_enter flt=%b exp 1", fault);
        else n_pass++;
        cyc(1, 4'd0, 16'h0055, 0, 0);
        cyc(1, 4'd9, 16'h0003, 0, 0);
        n_chk++; if (velocity !== '0 || fault !== 1'b1)
            $display("FAIL fc_ignored vel=%h flt=%b exp 0/1", velocity, fault);
        else n_pass++;
        cyc(1, 4'd9, 16'h0000, 0, 0);
        cyc(1, 4'd9, 16'h0003, 0, 0);
        n_chk++; if (velocity[VW-1:0] !== 11'h055 || velocity[2*VW-1:VW] !== 11'h401 ||
                     enable !== 1'b1 || fault !== 1'b0)
            $display("FAIL fc_recommit vel=%h en=%b flt=%b exp vel0=055", velocity, enable, fault);
        else n_pass++;
        cyc(0, 4'd0, 16'h0, 0, 4'd9);
        n_chk++; if (bus.rd_data !== 16'h0003)
            $display("FAIL fc_status got=%h exp=0003", bus.rd_data);
        else n_pass++;
    endtask

    task automatic test_random();
        logic we, tk;
        logic [3:0] a, ra;
        logic [15:0] d;
        int errs;
        errs = 0;
        for (int k = 0; k < 500; k++) begin
            we = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
                0: a = 4'd9;
                1: a = 4'd10;
                default: a = 4'($urandom_range(0, 15));
            endcase
            d = 16'($urandom);
            if (a == 4'd10) d = 16'($urandom_range(0, 4));
            tk = $urandom_range(0, 2) == 0;
            ra = 4'($urandom_range(0, 11));
            cyc(we, a, d, tk, ra);
            n_chk++; if (velocity !== exp_vel() && errs < 10) begin
                $display("FAIL rnd_vel k=%0d got=%h exp=%h", k, velocity, exp_vel());
                errs++;
            end else if (velocity === exp_vel()) n_pass++;
            n_chk++; if ({enable, fault, dirtime, steptime} !==
                         {m_state != 0, m_state == 2, T'(m_dt), T'(m_st)}) begin
                if (errs < 10)
                    $display("FAIL rnd_ctl k=%0d en=%b flt=%b dt=%h st=%h exp state=%0d dt=%h st=%h",
                             k, enable, fault, dirtime, steptime, m_state, m_dt, m_st);
                errs++;
            end else n_pass++;
            n_chk++; if (bus.rd_data !== exp_rd) begin
                if (errs < 10)
                    $display("FAIL rnd_rd k=%0d addr=%0d got=%h exp=%h", k, ra, bus.rd_data, exp_rd);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        model_reset();
        #12 nreset = 1'b1;
        test_reset();
        test_atomic_commit();
        test_watchdog_expiry();
        test_collision();
        test_wd_disabled();
        test_fault_ignores_commit();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
